// File: rtl/msg_aligner_fifo_if.sv
// msg_aligner_fifo_if: groups the message-in, message-out and status signals
// of msg_aligner_fifo. The master side drives incoming messages and out_ready.
// The slave side is the aligner/FIFO itself.
// Defining MSG_ALIGNER_STATS_EN adds the two statistics counters to the bundle.
interface msg_aligner_fifo_if #(
    parameter int DEPTH_LOG2 = 3
);
    // Extractor side: one right-justified message per in_valid pulse.
    logic                  in_valid;
    logic [255:0]          in_data;
    logic [31:0]           in_bytemask;

    // Order-book side: show-ahead valid/ready.
    logic                  out_ready;
    logic                  out_valid;
    logic [255:0]          out_data;
    logic [5:0]            out_length;

    // Status.
    logic [DEPTH_LOG2:0]   fifo_level;
    logic [15:0]           drop_count;
    logic [15:0]           err_count;
`ifdef MSG_ALIGNER_STATS_EN
    logic [31:0]           stat_msg_count;
    logic [31:0]           stat_byte_count;
`endif

    modport master (
`ifdef MSG_ALIGNER_STATS_EN
        input  stat_msg_count, stat_byte_count,
`endif
        output in_valid, in_data, in_bytemask, out_ready,
        input  out_valid, out_data, out_length, fifo_level, drop_count, err_count
    );

    modport slave (
`ifdef MSG_ALIGNER_STATS_EN
        output stat_msg_count, stat_byte_count,
`endif
        input  in_valid, in_data, in_bytemask, out_ready,
        output out_valid, out_data, out_length, fifo_level, drop_count, err_count
    );
endinterface

// File: rtl/msg_aligner_fifo.sv
// msg_aligner_fifo: accepts right-justified messages from the extractor.
// It checks the byte mask and left-justifies each legal message with its
// length tag. The result is buffered in a show-ahead FIFO of 2**DEPTH_LOG2
// entries for the order-book stage.
// The extractor cannot be stalled. When the FIFO is full, a whole message is
// dropped and counted. A message with an illegal mask is discarded and counted.
// Optional feature: define MSG_ALIGNER_STATS_EN to add stat_msg_count and
// stat_byte_count. These count messages written and bytes read out, and wrap.
module msg_aligner_fifo #(
    parameter int DEPTH_LOG2 = 3
) (
    input  logic              clk,
    input  logic              reset_n,
    msg_aligner_fifo_if.slave bus
);
    localparam int DEPTH = 1 << DEPTH_LOG2;

    typedef logic [DEPTH_LOG2-1:0] ptr_t;
    typedef logic [DEPTH_LOG2:0]   lvl_t;

    typedef struct packed {
        logic [255:0] data;
        logic [5:0]   len;
    } entry_t;

    // ------------------------------------------------------------------
    // Stage A: mask check and left-justification
    // ------------------------------------------------------------------
    logic [5:0]   len_c;
    logic [32:0]  ones_c;
    logic         legal_c;
    logic [255:0] masked_c;
    logic [8:0]   shamt_c;
    logic [255:0] aligned_c;

    // Count mask bits and zero every byte the mask does not cover.
    // NOTE: each always_comb output is given a default before any conditional or loop update, so no latch can be inferred.
    always_comb begin
        len_c    = '0;
        masked_c = '0;
        for (int i = 0; i < 32; i++) begin
            len_c              = len_c + 6'(bus.in_bytemask[i]);
            masked_c[8*i +: 8] = bus.in_data[8*i +: 8] & {8{bus.in_bytemask[i]}};
        end
    end

    // A legal mask is exactly len contiguous ones starting at bit 0, with len >= 1.
    assign ones_c    = (33'd1 << len_c) - 33'd1;
    assign legal_c   = (len_c != 6'd0) && ({1'b0, bus.in_bytemask} == ones_c);

    // Shift the last byte up so byte 0 lands at [255:248]. A 32-byte message is not shifted.
    assign shamt_c   = 9'd256 - {len_c, 3'b000};
    assign aligned_c = masked_c << shamt_c;

    logic         a_vld_q, a_vld_d;
    logic [255:0] a_data_q, a_data_d;
    logic [5:0]   a_len_q, a_len_d;

    assign a_vld_d  = bus.in_valid & legal_c;
    assign a_data_d = aligned_c;
    assign a_len_d  = len_c;

    // Align register: holds one validated message for the FIFO write on the next edge.
    // NOTE: registers use non-blocking assignments, so every flop samples the pre-edge values of the others.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            a_vld_q  <= 1'b0;
            a_data_q <= '0;
            a_len_q  <= '0;
        end else begin
            a_vld_q <= a_vld_d;
            if (a_vld_d) begin
                a_data_q <= a_data_d;
                a_len_q  <= a_len_d;
            end
        end
    end

    // ------------------------------------------------------------------
    // Stage B: FIFO control
    // ------------------------------------------------------------------
    entry_t mem_q [DEPTH];
    entry_t head_c;

    ptr_t   wr_ptr_q, wr_ptr_d;
    ptr_t   rd_ptr_q, rd_ptr_d;
    lvl_t   level_q,  level_d;
    logic [15:0] drop_count_q, drop_count_d;
    logic [15:0] err_count_q,  err_count_d;

    logic   empty_c;
    logic   full_c;
    logic   do_read_c;
    logic   do_write_c;
    logic   drop_c;
    logic   err_c;

    assign empty_c    = (level_q == '0);
    assign full_c     = (level_q == lvl_t'(DEPTH));
    // out_ready means nothing while the FIFO is empty.
    assign do_read_c  = !empty_c && bus.out_ready;
    // A read on the same edge frees a slot, so a full FIFO can still accept a write.
    assign do_write_c = a_vld_q && (!full_c || do_read_c);
    assign drop_c     = a_vld_q && full_c && !do_read_c;
    assign err_c      = bus.in_valid && !legal_c;

    // Next-state logic for the pointers, the occupancy and the saturating event counters.
    always_comb begin
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        level_d      = level_q;
        drop_count_d = drop_count_q;
        err_count_d  = err_count_q;

        if (do_write_c) begin
            wr_ptr_d = wr_ptr_q + ptr_t'(1);
        end
        if (do_read_c) begin
            rd_ptr_d = rd_ptr_q + ptr_t'(1);
        end

        unique case ({do_write_c, do_read_c})
            2'b10:   level_d = level_q + lvl_t'(1);
            2'b01:   level_d = level_q - lvl_t'(1);
            default: level_d = level_q;
        endcase

        if (drop_c && (drop_count_q != 16'hFFFF)) begin
            drop_count_d = drop_count_q + 16'd1;
        end
        if (err_c && (err_count_q != 16'hFFFF)) begin
            err_count_d = err_count_q + 16'd1;
        end
    end

    // Control state: pointers, level and counters, all cleared by the asynchronous reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            level_q      <= '0;
            drop_count_q <= '0;
            err_count_q  <= '0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            level_q      <= level_d;
            drop_count_q <= drop_count_d;
            err_count_q  <= err_count_d;
        end
    end

    // Storage array write port.
    // NOTE: the storage array has no reset. An entry is only read after it has been written, and the outputs are forced to zero while the FIFO is empty.
    always_ff @(posedge clk) begin
        if (do_write_c) begin
            mem_q[wr_ptr_q] <= {a_data_q, a_len_q};
        end
    end

    // Show-ahead head. Zeroing the head while empty keeps the outputs at zero after reset.
    assign head_c         = mem_q[rd_ptr_q];
    assign bus.out_valid  = !empty_c;
    assign bus.out_data   = empty_c ? '0 : head_c.data;
    assign bus.out_length = empty_c ? '0 : head_c.len;
    assign bus.fifo_level = level_q;
    assign bus.drop_count = drop_count_q;
    assign bus.err_count  = err_count_q;

`ifdef MSG_ALIGNER_STATS_EN
    // ------------------------------------------------------------------
    // Optional statistics: wrap-around counters
    // ------------------------------------------------------------------
    logic [31:0] stat_msg_q,  stat_msg_d;
    logic [31:0] stat_byte_q, stat_byte_d;

    // Count messages written, and accumulate the lengths of messages read out.
    always_comb begin
        stat_msg_d  = stat_msg_q;
        stat_byte_d = stat_byte_q;
        if (do_write_c) begin
            stat_msg_d = stat_msg_q + 32'd1;
        end
        if (do_read_c) begin
            stat_byte_d = stat_byte_q + 32'(head_c.len);
        end
    end

    // Statistics registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stat_msg_q  <= '0;
            stat_byte_q <= '0;
        end else begin
            stat_msg_q  <= stat_msg_d;
            stat_byte_q <= stat_byte_d;
        end
    end

    assign bus.stat_msg_count  = stat_msg_q;
    assign bus.stat_byte_count = stat_byte_q;
`endif

endmodule
